// File: rtl/cache_pkg.sv
// Shared widths, address field positions, the controller state encoding and
// pseudo-LRU helper functions for the cache controller.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 22;
  localparam int INDEX_W  = 8;
  localparam int WAY_W    = 2;
  localparam int PLRU_W   = 3;

  // Byte address split: tag above the index, word offset bits [1:0] unused.
  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 10;
  localparam int INDEX_MSB = 9;
  localparam int INDEX_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    REFILL,
    FILL,
    MEMWR,
    RESPOND
  } state_e;

  // Tree pseudo-LRU: bit0 picks the half, bit1 the way in the low half,
  // bit2 the way in the high half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    if (bits[0]) way = bits[2] ? 2'd3 : 2'd2;
    else         way = bits[1] ? 2'd1 : 2'd0;
    return way;
  endfunction

  // Record an access to way w: point bit0 away from the accessed half and
  // set the bit of that half from which way was touched.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  w);
    logic [PLRU_W-1:0] nbits;
    nbits    = bits;
    nbits[0] = ~w[1];
    if (!w[1]) nbits[1] = (w == 2'd0);
    else       nbits[2] = (w == 2'd2);
    return nbits;
  endfunction

endpackage

// File: rtl/cache_ctrl_plru_table.sv
// Per-set pseudo-LRU state. Kept in flops rather than RAM because reset must
// clear every entry at once. Victim lookup is combinational on the read index.
module plru_table
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic [WAY_W-1:0]   victim_o,
  input  logic               upd_en_i,
  input  logic [INDEX_W-1:0] upd_index_i,
  input  logic [WAY_W-1:0]   upd_way_i
);

  logic [PLRU_W-1:0] lru_q [NUM_SETS];

  // Clear all entries on reset; otherwise apply the access update to one set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) lru_q[i] <= '0;
    end else if (upd_en_i) begin
      lru_q[upd_index_i] <= plru_touch(lru_q[upd_index_i], upd_way_i);
    end
  end

  assign victim_o = plru_victim(lru_q[rd_index_i]);

endmodule

// File: rtl/cache_ctrl.sv
// 4-way set-associative cache controller: write-through, no write-allocate,
// pseudo-LRU replacement. The tag/data array lives outside this block and
// returns the indexed set one cycle after arr_index is presented.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_ready,
  output logic [INDEX_W-1:0] arr_index,
  input  logic [TAG_W-1:0]   arr_tag0,
  input  logic [TAG_W-1:0]   arr_tag1,
  input  logic [TAG_W-1:0]   arr_tag2,
  input  logic [TAG_W-1:0]   arr_tag3,
  input  logic               arr_valid0,
  input  logic               arr_valid1,
  input  logic               arr_valid2,
  input  logic               arr_valid3,
  input  logic [DATA_W-1:0]  arr_data0,
  input  logic [DATA_W-1:0]  arr_data1,
  input  logic [DATA_W-1:0]  arr_data2,
  input  logic [DATA_W-1:0]  arr_data3,
  output logic               arr_we,
  output logic [WAY_W-1:0]   arr_way,
  output logic [TAG_W-1:0]   arr_wtag,
  output logic [DATA_W-1:0]  arr_wdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;      // word-aligned captured address
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               hit_q;
  logic [WAY_W-1:0]   hit_way_q;
  logic [WAY_W-1:0]   victim_q;

  logic [DATA_W-1:0]  cpu_rdata_q;
  logic               cpu_ready_q;
  logic [INDEX_W-1:0] arr_index_q;
  logic               arr_we_q;
  logic [WAY_W-1:0]   arr_way_q;
  logic [TAG_W-1:0]   arr_wtag_q;
  logic [DATA_W-1:0]  arr_wdata_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  // Byte-offset bits never reach any decision.
  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_addr[1:0];

  logic [TAG_W-1:0]  cap_tag;
  assign cap_tag = addr_q[TAG_MSB:TAG_LSB];

  // Gather the per-way array ports so the compare can be generated.
  logic [TAG_W-1:0]  tag_arr  [NUM_WAYS];
  logic [DATA_W-1:0] data_arr [NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_vec;
  logic [NUM_WAYS-1:0] hit_vec;

  assign tag_arr[0]  = arr_tag0;
  assign tag_arr[1]  = arr_tag1;
  assign tag_arr[2]  = arr_tag2;
  assign tag_arr[3]  = arr_tag3;
  assign data_arr[0] = arr_data0;
  assign data_arr[1] = arr_data1;
  assign data_arr[2] = arr_data2;
  assign data_arr[3] = arr_data3;
  assign valid_vec   = {arr_valid3, arr_valid2, arr_valid1, arr_valid0};

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_cmp
    assign hit_vec[gi] = valid_vec[gi] && (tag_arr[gi] == cap_tag);
  end

  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] plru_way;

  assign any_hit = |hit_vec;

  // Lowest-numbered hitting way wins when several ways match.
  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = w[WAY_W-1:0];
    end
  end

  // Fill the lowest invalid way first; fall back to pseudo-LRU when the set is full.
  always_comb begin
    victim_way = plru_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim_way = w[WAY_W-1:0];
    end
  end

  // Touch LRU on any hit (seen in COMPARE) and on the array write of a read fill.
  logic             plru_upd_en;
  logic [WAY_W-1:0] plru_upd_way;

  assign plru_upd_en  = ((state_q == COMPARE) && any_hit) ||
                        ((state_q == FILL) && !we_q);
  assign plru_upd_way = (state_q == FILL) ? arr_way_q : hit_way;

  plru_table #(
    .NUM_SETS (NUM_SETS)
  ) u_plru (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index_i  (arr_index_q),
    .victim_o    (plru_way),
    .upd_en_i    (plru_upd_en),
    .upd_index_i (arr_index_q),
    .upd_way_i   (plru_upd_way)
  );

  // Controller FSM with all outputs registered; reset abandons any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      victim_q    <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      arr_index_q <= '0;
      arr_we_q    <= 1'b0;
      arr_way_q   <= '0;
      arr_wtag_q  <= '0;
      arr_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      arr_we_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q      <= {cpu_addr[ADDR_W-1:2], 2'b00};
            we_q        <= cpu_we;
            wdata_q     <= cpu_wdata;
            arr_index_q <= cpu_addr[INDEX_MSB:INDEX_LSB];
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          state_q <= COMPARE;
        end
        COMPARE: begin
          hit_q     <= any_hit;
          hit_way_q <= hit_way;
          victim_q  <= victim_way;
          if (we_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= MEMWR;
          end else if (any_hit) begin
            cpu_rdata_q <= data_arr[hit_way];
            cpu_ready_q <= 1'b1;
            state_q     <= RESPOND;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            arr_we_q    <= 1'b1;
            arr_way_q   <= victim_q;
            arr_wtag_q  <= cap_tag;
            arr_wdata_q <= mem_rdata;
            state_q     <= FILL;
          end
        end
        MEMWR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (hit_q) begin
              arr_we_q    <= 1'b1;
              arr_way_q   <= hit_way_q;
              arr_wtag_q  <= cap_tag;
              arr_wdata_q <= wdata_q;
              state_q     <= FILL;
            end else begin
              cpu_ready_q <= 1'b1;
              state_q     <= RESPOND;
            end
          end
        end
        FILL: begin
          // For a read fill the written word is also the returned data.
          if (!we_q) cpu_rdata_q <= arr_wdata_q;
          cpu_ready_q <= 1'b1;
          state_q     <= RESPOND;
        end
        RESPOND: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign arr_index = arr_index_q;
  assign arr_we    = arr_we_q;
  assign arr_way   = arr_way_q;
  assign arr_wtag  = arr_wtag_q;
  assign arr_wdata = arr_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
